// File: rtl/dpram_port_arbiter_if.sv
// dpram_port_arbiter_if: requester-side bus between NREQ clients and the dual-port RAM arbiter.
//   req_valid/req_we/req_addr/req_wdata : requester -> arbiter request, packed per requester
//   req_ready                            : arbiter -> requester combinational grant
//   rsp_valid/rsp_rdata                  : arbiter -> requester response, one cycle after acceptance
//   modport master : requester side, modport slave : arbiter side
interface dpram_port_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N = 4,
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_we;
  logic [NREQ*N-1:0] req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] rsp_valid;
  logic [NREQ*WIDTH-1:0] rsp_rdata;
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: shares the A/B ports of a dual-port RAM among NREQ requesters, two
// round-robin grants per cycle, with responses routed back one cycle after acceptance.
//   clk, rst                     : clock, synchronous active-high reset
//   bus (slave)                  : requester bus (valid/we/addr/wdata in, ready/rsp out)
//   ram_we_*/ram_addr_*/ram_din_*: RAM port drive, zero when a port is idle
//   ram_dout_a/b                 : registered RAM read data (read-before-write)
//   DPRAM_ARB_STATS_EN           : when defined, adds saturating stat_gnt_a/stat_gnt_b/stat_conflict
module dpram_port_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int N = 4,
  parameter int NREQ = 4
) (
  input  logic clk,
  input  logic rst,
  dpram_port_arbiter_if.slave bus,
  output logic ram_we_a,
  output logic ram_we_b,
  output logic [N-1:0] ram_addr_a,
  output logic [N-1:0] ram_addr_b,
  output logic [WIDTH-1:0] ram_din_a,
  output logic [WIDTH-1:0] ram_din_b,
  input  logic [WIDTH-1:0] ram_dout_a,
  input  logic [WIDTH-1:0] ram_dout_b
`ifdef DPRAM_ARB_STATS_EN
  ,
  output logic [15:0] stat_gnt_a,
  output logic [15:0] stat_gnt_b,
  output logic [15:0] stat_conflict
`endif
);
  localparam int PW = $clog2(NREQ);
  if (DEPTH > 2 ** N) begin : g_bad_depth
    $error("DEPTH exceeds 2**N");
  end
  logic [PW-1:0] ptr, a_idx, b_idx, idx, ga_i, gb_i;
  logic a_v, b_v, b_ok, hz, ga_v, gb_v;
  logic [N-1:0] addr_u [NREQ];
  logic [WIDTH-1:0] wdata_u [NREQ];
  logic [NREQ*WIDTH-1:0] rdata_q;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] x);
    return x == PW'(NREQ - 1) ? '0 : x + 1'b1;
  endfunction
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_u[i] = bus.req_addr[i*N +: N];
    assign wdata_u[i] = bus.req_wdata[i*WIDTH +: WIDTH];
  end
  // rotate from ptr: first valid requester takes port A, second takes port B
  always_comb begin
    a_v = 1'b0;
    b_v = 1'b0;
    a_idx = '0;
    b_idx = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (bus.req_valid[idx] && !rst) begin
        if (!a_v) begin
          a_v = 1'b1;
          a_idx = idx;
        end else if (!b_v) begin
          b_v = 1'b1;
          b_idx = idx;
        end
      end
    end
  end
  // same address with a write on either side would make the RAM result order-dependent,
  // so port B backs off; two reads of one address are harmless
  assign hz = a_v && b_v && addr_u[a_idx] == addr_u[b_idx] && (bus.req_we[a_idx] || bus.req_we[b_idx]);
  assign b_ok = b_v && !hz;
  assign ram_we_a = a_v && bus.req_we[a_idx];
  assign ram_we_b = b_ok && bus.req_we[b_idx];
  assign ram_addr_a = a_v ? addr_u[a_idx] : '0;
  assign ram_addr_b = b_ok ? addr_u[b_idx] : '0;
  assign ram_din_a = a_v ? wdata_u[a_idx] : '0;
  assign ram_din_b = b_ok ? wdata_u[b_idx] : '0;
  // RAM read data lands the cycle after grant, so the responding slice passes ram_dout
  // straight through and rdata_q only holds it for the idle cycles that follow
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.rsp_rdata = rdata_q;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = (a_v && a_idx == PW'(i)) || (b_ok && b_idx == PW'(i));
      bus.rsp_valid[i] = !rst && ((ga_v && ga_i == PW'(i)) || (gb_v && gb_i == PW'(i)));
      bus.rsp_rdata[i*WIDTH +: WIDTH] = ga_v && ga_i == PW'(i) ? ram_dout_a :
                                        gb_v && gb_i == PW'(i) ? ram_dout_b :
                                        rdata_q[i*WIDTH +: WIDTH];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      ga_v <= 1'b0;
      gb_v <= 1'b0;
      ga_i <= '0;
      gb_i <= '0;
      rdata_q <= '0;
    end else begin
      ptr <= b_ok ? nxt(b_idx) : a_v ? nxt(a_idx) : ptr;
      ga_v <= a_v;
      gb_v <= b_ok;
      ga_i <= a_idx;
      gb_i <= b_idx;
      rdata_q <= bus.rsp_rdata;
    end
  end
`ifdef DPRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_gnt_a <= '0;
      stat_gnt_b <= '0;
      stat_conflict <= '0;
    end else begin
      stat_gnt_a <= stat_gnt_a + 16'(a_v && stat_gnt_a != '1);
      stat_gnt_b <= stat_gnt_b + 16'(b_ok && stat_gnt_b != '1);
      stat_conflict <= stat_conflict + 16'(hz && stat_conflict != '1);
    end
  end
`endif
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter: directed bench with a RAM model and a response scoreboard.
module tb_dpram_port_arbiter;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int N = 4;
  localparam int NREQ = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dpram_port_arbiter_if #(.WIDTH(WIDTH), .N(N), .NREQ(NREQ)) bus ();
  logic ram_we_a, ram_we_b;
  logic [N-1:0] ram_addr_a, ram_addr_b;
  logic [WIDTH-1:0] ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
`ifdef DPRAM_ARB_STATS_EN
  logic [15:0] stat_gnt_a, stat_gnt_b, stat_conflict;
`endif
  dpram_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N(N), .NREQ(NREQ)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .ram_we_a(ram_we_a),
    .ram_we_b(ram_we_b),
    .ram_addr_a(ram_addr_a),
    .ram_addr_b(ram_addr_b),
    .ram_din_a(ram_din_a),
    .ram_din_b(ram_din_b),
    .ram_dout_a(ram_dout_a),
    .ram_dout_b(ram_dout_b)
`ifdef DPRAM_ARB_STATS_EN
    ,
    .stat_gnt_a(stat_gnt_a),
    .stat_gnt_b(stat_gnt_b),
    .stat_conflict(stat_conflict)
`endif
  );
  // dual-port RAM: registered read-before-write, cleared by reset
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ram_dout_a <= '0;
      ram_dout_b <= '0;
    end else begin
      ram_dout_a <= mem[ram_addr_a];
      ram_dout_b <= mem[ram_addr_b];
      if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
      if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
    end
  end
  typedef struct {
    int idx;
    logic [WIDTH-1:0] d;
  } exp_t;
  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (bus.rsp_valid[i] !== 1'b0) begin
        int k;
        k = -1;
        for (int j = 0; j < sb.size(); j++) if (k < 0 && sb[j].idx == i) k = j;
        n_tests++;
        if (k < 0) begin
          n_fail++;
          $display("FAIL rsp%0d_unexpected: got rsp_valid=%b data %0h, expected no response",
                   i, bus.rsp_valid[i], bus.rsp_rdata[i*WIDTH +: WIDTH]);
        end else begin
          if (bus.rsp_rdata[i*WIDTH +: WIDTH] !== sb[k].d) begin
            n_fail++;
            $display("FAIL rsp%0d_data: got %0h, expected %0h", i, bus.rsp_rdata[i*WIDTH +: WIDTH], sb[k].d);
          end
          sb.delete(k);
        end
      end
    end
  end
  // one clock of stimulus: drive after posedge, check ready at negedge, queue expected responses
  task automatic cyc(input string nm, input logic r, input logic [3:0] v, input logic [3:0] w,
                     input logic [15:0] a, input logic [31:0] wd, input logic [3:0] er,
                     input logic [31:0] ed, input logic push);
    @(posedge clk);
    #1;
    rst = r;
    bus.req_valid = v;
    bus.req_we = w;
    bus.req_addr = a;
    bus.req_wdata = wd;
    @(negedge clk);
    chk({nm, "_ready"}, 32'(bus.req_ready), 32'(er));
    if (push) for (int i = 0; i < NREQ; i++) if (er[i]) sb.push_back('{idx: i, d: ed[i*8 +: 8]});
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_we = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    cyc("rst0", 1, 4'hF, 4'hF, 16'h3210, 32'h04030201, 4'h0, 32'h0, 0);
    chk("rst0_we_a", 32'(ram_we_a), 32'h0);
    chk("rst0_we_b", 32'(ram_we_b), 32'h0);
    chk("rst0_rsp", 32'(bus.rsp_valid), 32'h0);
    cyc("rst1", 1, 4'hF, 4'hF, 16'h3210, 32'h04030201, 4'h0, 32'h0, 0);
    chk("rst1_rsp", 32'(bus.rsp_valid), 32'h0);
    cyc("rr0", 0, 4'hF, 4'h0, 16'h4210, 32'h0, 4'b0011, 32'h0, 1);
    chk("rr0_addr_a", 32'(ram_addr_a), 32'h0);
    chk("rr0_addr_b", 32'(ram_addr_b), 32'h1);
    cyc("rr1", 0, 4'hF, 4'h0, 16'h4210, 32'h0, 4'b1100, 32'h0, 1);
    chk("rr1_addr_a", 32'(ram_addr_a), 32'h2);
    chk("rr1_addr_b", 32'(ram_addr_b), 32'h4);
    cyc("rr2", 0, 4'hF, 4'h0, 16'h4210, 32'h0, 4'b0011, 32'h0, 1);
    cyc("rr3", 0, 4'hF, 4'h0, 16'h4210, 32'h0, 4'b1100, 32'h0, 1);
    cyc("wr", 0, 4'b0001, 4'b0001, 16'h0003, 32'h000000A5, 4'b0001, 32'h0, 1);
    chk("wr_we_a", 32'(ram_we_a), 32'h1);
    chk("wr_we_b", 32'(ram_we_b), 32'h0);
    chk("wr_din_a", 32'(ram_din_a), 32'hA5);
    chk("wr_addr_b_idle", 32'(ram_addr_b), 32'h0);
    cyc("rd2", 0, 4'b0100, 4'h0, 16'h0300, 32'h0, 4'b0100, 32'h00A50000, 1);
    chk("rd2_addr_a", 32'(ram_addr_a), 32'h3);
    cyc("rd3", 0, 4'b1000, 4'h0, 16'h3000, 32'h0, 4'b1000, 32'hA5000000, 1);
    cyc("rd0", 0, 4'b0001, 4'h0, 16'h0000, 32'h0, 4'b0001, 32'h0, 1);
    cyc("hz", 0, 4'b0110, 4'b0010, 16'h0770, 32'h00003C00, 4'b0010, 32'h0, 1);
    chk("hz_we_a", 32'(ram_we_a), 32'h1);
    chk("hz_we_b", 32'(ram_we_b), 32'h0);
    cyc("hz2", 0, 4'b0100, 4'h0, 16'h0700, 32'h0, 4'b0100, 32'h003C0000, 1);
`ifdef DPRAM_ARB_STATS_EN
    chk("stat_conflict", 32'(stat_conflict), 32'h1);
`endif
    cyc("w5", 0, 4'b1000, 4'b1000, 16'h5000, 32'h11000000, 4'b1000, 32'h0, 1);
    cyc("rr5", 0, 4'b0011, 4'h0, 16'h0055, 32'h0, 4'b0011, 32'h00001111, 1);
    chk("rr5_addr_a", 32'(ram_addr_a), 32'h5);
    chk("rr5_addr_b", 32'(ram_addr_b), 32'h5);
    cyc("ww", 0, 4'b0011, 4'b0011, 16'h0098, 32'h00006655, 4'b0011, 32'h0, 1);
    chk("ww_we_b", 32'(ram_we_b), 32'h1);
    chk("ww_addr_b", 32'(ram_addr_b), 32'h9);
    chk("ww_din_b", 32'(ram_din_b), 32'h66);
    cyc("mid", 0, 4'b0001, 4'h0, 16'h0003, 32'h0, 4'b0001, 32'h0, 0);
    cyc("mrst0", 1, 4'h0, 4'h0, 16'h0, 32'h0, 4'h0, 32'h0, 0);
    chk("mrst0_rsp", 32'(bus.rsp_valid), 32'h0);
    chk("mrst0_we_a", 32'(ram_we_a), 32'h0);
    cyc("mrst1", 1, 4'h0, 4'h0, 16'h0, 32'h0, 4'h0, 32'h0, 0);
    cyc("post", 0, 4'b0001, 4'h0, 16'h0003, 32'h0, 4'b0001, 32'h0, 1);
    for (int i = 0; i < 3; i++) cyc("idle", 0, 4'h0, 4'h0, 16'h0, 32'h0, 4'h0, 32'h0, 0);
    chk("drain_pending", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
